dma_burst_streamer: RTL and testbench
=====================================

Name: dma_burst_streamer

Overview:
- Upstream stage of the DMA-to-AXI interface. One instance per direction: a read streamer and a write streamer.
- Takes a transfer descriptor (start address, byte count) from the DMA FSM.
- Splits it into a sequence of AXI-legal requests (addr, alen, size, strb, valid) presented over a valid/ready handshake.
- A single per-request strobe applies to every beat of that request. Unaligned head and tail bytes are therefore issued as single-beat requests. Aligned middle bytes go as full-strobe INCR bursts that never cross a 4 KB boundary.

Parameters:
- ADDR_W, 32, address width (>=12).
- DATA_W, 64, AXI data width in bits; BYTES = DATA_W/8, power of two, 8..64.
- LEN_W, 32, byte-count width.
- MAX_BEATS, 256, maximum beats per burst (1..256).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start_i  in  1  descriptor start pulse; accepted only in IDLE.
- addr_i  in  ADDR_W  transfer start address.
- num_bytes_i  in  LEN_W  transfer length in bytes.
- abort_i  in  1  stop transfer after the current request.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse: transfer completed.
- req_addr_o  out  ADDR_W  request address.
- req_alen_o  out  8  beats-1.
- req_size_o  out  3  log2(BYTES), constant.
- req_strb_o  out  BYTES  byte mask applied to every beat.
- req_valid_o  out  1  request valid.
- req_ready_i  in  1  request accepted (AXI AR/AW handshake).

Behaviour:
- Reset values: all outputs 0 except req_size_o = log2(BYTES). State is IDLE, internal address and remaining-byte count are 0. An asserted reset forces req_valid_o low immediately, including mid-request.
- State IDLE:
  - start_i=1 with num_bytes_i!=0: latch cur_addr=addr_i and left=num_bytes_i, go to RUN. req_valid_o rises the next cycle.
  - start_i=1 with num_bytes_i==0: go to DONE; no request is issued.
  - start_i in RUN or DONE is ignored.
- State RUN: req_valid_o=1. Request fields are computed combinationally from the registered cur_addr and left. off = cur_addr[log2(BYTES)-1:0].
  - Partial request (off!=0 or left<BYTES): alen=0. strb bits [off .. min(off+left,BYTES)-1] are set. consumed = min(BYTES-off, left).
  - Aligned request (otherwise): beats = min(left/BYTES, MAX_BEATS, (4096-cur_addr[11:0])/BYTES). alen=beats-1, strb all ones, consumed = beats*BYTES.
  - req_addr_o = cur_addr (not aligned down).
- Handshake:
  - Request fields and req_valid_o must stay stable while req_valid_o=1 and req_ready_i=0.
  - On req_valid_o && req_ready_i: cur_addr += consumed, left -= consumed. Unsigned arithmetic; left never underflows.
  - If left becomes 0, go to DONE. Otherwise stay in RUN; the next request is presented the following cycle with no bubble.
- State DONE: done_o=1 for exactly one cycle, then go to IDLE.
- abort_i:
  - Sampled every cycle in RUN and held internally as abort_pend.
  - If no request is awaiting acceptance, go to IDLE at once.
  - Otherwise keep req_valid_o high until the current handshake completes, then go to IDLE.
  - done_o is not pulsed on abort. abort_pend is cleared in IDLE.
- Simultaneous events:
  - Final handshake in the same cycle as abort_i: goes to DONE; completion wins.
  - Address wrap past 2^ADDR_W: wraps modulo, no error.
- busy_o = (state==RUN).

Optional Feature:
- Macro DMA_STREAMER_FIXED_ADDR_EN.
- When defined:
  - Adds input mode_fixed_i (1 bit), latched with start_i.
  - With the mode set, cur_addr never increments.
  - Every request is single-beat (alen=0) with strb = partial mask computed from off and left, consumed as in the partial rule. This is used for peripheral FIFO ports.
- When undefined: the port is absent and behaviour is always incrementing.

Test Plan:
- Aligned burst: DATA_W=64, addr 0x1000, 64 bytes, ready=1 -> one request addr 0x1000, alen 7, strb 0xFF. done_o pulses 1 cycle after the handshake; busy_o low after that.
- Unaligned head and tail: addr 0x1003, 10 bytes -> request 0x1003 alen 0 strb 0xF8, then 0x1008 alen 0 strb 0x1F, then done_o.
- 4 KB split and burst cap: addr 0x0FF0, 32 bytes -> 0x0FF0 alen 1, then 0x1000 alen 1. Separately, addr 0x0, 4096 bytes, MAX_BEATS=256 -> 0x000 alen 255, then 0x800 alen 255.
- Backpressure: ready held 0 for 5 cycles with a request valid -> valid, addr, alen and strb unchanged all 5 cycles; the next request appears 1 cycle after ready=1.
- Abort and reset: abort_i during a stalled request -> handshake completes, state returns to IDLE, done_o never pulses. Asserting rst mid-RUN -> req_valid_o drops with no clock edge.
- Zero-length start: num_bytes_i=0 -> no req_valid_o; done_o pulses the next cycle. With DMA_STREAMER_FIXED_ADDR_EN defined, mode_fixed_i=1, addr 0x2000, 24 bytes -> three requests at 0x2000, each alen 0, strb 0xFF.

Source files
------------

// File: rtl/dma_burst_streamer.sv
// Splits a (start address, byte count) descriptor into AXI-legal requests.
// Optional fixed-address mode: DMA_STREAMER_FIXED_ADDR_EN.
module dma_burst_streamer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int LEN_W     = 32,
  parameter int MAX_BEATS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  num_bytes_i,
  input  logic              abort_i,
`ifdef DMA_STREAMER_FIXED_ADDR_EN
  input  logic              mode_fixed_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [7:0]        req_alen_o,
  output logic [2:0]        req_size_o,
  output logic [DATA_W/8-1:0] req_strb_o,
  output logic              req_valid_o,
  input  logic              req_ready_i
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  left;
  logic              abort_pend;
  logic              fixed_md;

  logic [OFF_W-1:0]  off;
  logic              partial;
  logic              fire;
  logic [LEN_W-1:0]  avail;
  logic [LEN_W-1:0]  cons_p;
  logic [LEN_W-1:0]  consumed;
  logic [LEN_W-1:0]  left_nxt;
  logic [12:0]       page_bytes;
  logic [LEN_W-1:0]  page_beats;
  logic [LEN_W-1:0]  word_beats;
  logic [LEN_W-1:0]  beats;
  logic [7:0]        alen;
  logic [BYTES-1:0]  strb;

`ifdef DMA_STREAMER_FIXED_ADDR_EN
  logic fixed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fixed_q <= 1'b0;
    end else if (state == IDLE && start_i) begin
      fixed_q <= mode_fixed_i;
    end
  end

  assign fixed_md = fixed_q;
`else
  assign fixed_md = 1'b0;
`endif

  // Request decode from registered cur_addr/left only, so fields hold under stall.
  always_comb begin
    off        = cur_addr[OFF_W-1:0];
    partial    = fixed_md || (off != '0) || (left < LEN_W'(BYTES));
    avail      = LEN_W'(BYTES) - LEN_W'(off);
    cons_p     = (left < avail) ? left : avail;
    page_bytes = 13'd4096 - {1'b0, cur_addr[11:0]};
    page_beats = LEN_W'(page_bytes >> OFF_W);
    word_beats = left >> OFF_W;
    beats      = word_beats;
    if (LEN_W'(MAX_BEATS) < beats) beats = LEN_W'(MAX_BEATS);
    if (page_beats < beats)        beats = page_beats;
    strb       = '0;
    alen       = 8'd0;
    consumed   = cons_p;
    if (partial) begin
      for (int i = 0; i < BYTES; i++) begin
        strb[i] = (LEN_W'(i) >= LEN_W'(off)) &&
                  (LEN_W'(i) < LEN_W'(off) + cons_p);
      end
    end else begin
      strb     = '1;
      alen     = 8'(beats - LEN_W'(1));
      consumed = beats << OFF_W;
    end
    left_nxt = left - consumed;
  end

  assign fire = (state == RUN) && req_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = (num_bytes_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Completion beats abort when both land on the last handshake.
        if (fire) begin
          if (left_nxt == '0) begin
            state_nxt = DONE;
          end else if (abort_i || abort_pend) begin
            state_nxt = IDLE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state == RUN);
    done_o      = (state == DONE);
    req_valid_o = (state == RUN);
    req_size_o  = 3'(OFF_W);
    req_addr_o  = '0;
    req_alen_o  = '0;
    req_strb_o  = '0;
    if (state == RUN) begin
      req_addr_o = cur_addr;
      req_alen_o = alen;
      req_strb_o = strb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr   <= '0;
      left       <= '0;
      abort_pend <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          abort_pend <= 1'b0;
          if (start_i) begin
            cur_addr <= addr_i;
            left     <= num_bytes_i;
          end
        end
        RUN: begin
          if (abort_i) abort_pend <= 1'b1;
          if (fire) begin
            left <= left_nxt;
            if (!fixed_md) cur_addr <= cur_addr + ADDR_W'(consumed);
          end
        end
        default: abort_pend <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_burst_streamer.sv
// Directed bench for dma_burst_streamer (64-bit data, 256-beat cap).
module tb_dma_burst_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] addr_i;
  logic [31:0] num_bytes_i;
  logic        abort_i;
`ifdef DMA_STREAMER_FIXED_ADDR_EN
  logic        mode_fixed_i;
`endif
  logic        busy_o;
  logic        done_o;
  logic [31:0] req_addr_o;
  logic [7:0]  req_alen_o;
  logic [2:0]  req_size_o;
  logic [7:0]  req_strb_o;
  logic        req_valid_o;
  logic        req_ready_i;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dma_burst_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .addr_i      (addr_i),
    .num_bytes_i (num_bytes_i),
    .abort_i     (abort_i),
`ifdef DMA_STREAMER_FIXED_ADDR_EN
    .mode_fixed_i(mode_fixed_i),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o),
    .req_addr_o  (req_addr_o),
    .req_alen_o  (req_alen_o),
    .req_size_o  (req_size_o),
    .req_strb_o  (req_strb_o),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input string tag, input logic [31:0] a,
                     input logic [7:0] l, input logic [7:0] s);
    chk({tag, " valid"}, 32'(req_valid_o), 32'd1);
    chk({tag, " addr"}, req_addr_o, a);
    chk({tag, " alen"}, 32'(req_alen_o), 32'(l));
    chk({tag, " strb"}, 32'(req_strb_o), 32'(s));
  endtask

  task automatic go(input logic [31:0] a, input logic [31:0] n);
    start_i     = 1'b1;
    addr_i      = a;
    num_bytes_i = n;
    tick();
    start_i     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    addr_i = '0;
    num_bytes_i = '0;
    abort_i = 1'b0;
    req_ready_i = 1'b1;
`ifdef DMA_STREAMER_FIXED_ADDR_EN
    mode_fixed_i = 1'b0;
`endif
    #12;
    chk("rst valid", 32'(req_valid_o), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst size", 32'(req_size_o), 32'd3);
    chk("rst addr", req_addr_o, 32'd0);
    chk("rst strb", 32'(req_strb_o), 32'd0);
    rst = 1'b0;
    tick();

    go(32'h1000, 32'd64);
    req("aligned", 32'h1000, 8'd7, 8'hFF);
    chk("aligned busy", 32'(busy_o), 32'd1);
    tick();
    chk("aligned done", 32'(done_o), 32'd1);
    chk("aligned valid off", 32'(req_valid_o), 32'd0);
    tick();
    chk("aligned done 1cyc", 32'(done_o), 32'd0);
    chk("aligned busy off", 32'(busy_o), 32'd0);

    go(32'h1003, 32'd10);
    req("head", 32'h1003, 8'd0, 8'hF8);
    tick();
    req("tail", 32'h1008, 8'd0, 8'h1F);
    tick();
    chk("unal done", 32'(done_o), 32'd1);
    tick();

    go(32'h0FF0, 32'd32);
    req("4k a", 32'h0FF0, 8'd1, 8'hFF);
    tick();
    req("4k b", 32'h1000, 8'd1, 8'hFF);
    tick();
    chk("4k done", 32'(done_o), 32'd1);
    tick();

    go(32'h0, 32'd4096);
    req("cap a", 32'h0, 8'd255, 8'hFF);
    tick();
    req("cap b", 32'h800, 8'd255, 8'hFF);
    tick();
    chk("cap done", 32'(done_o), 32'd1);
    tick();

    req_ready_i = 1'b0;
    go(32'h2004, 32'd16);
    for (int i = 0; i < 5; i++) begin
      req("stall", 32'h2004, 8'd0, 8'hF0);
      tick();
    end
    req_ready_i = 1'b1;
    req("stall rel", 32'h2004, 8'd0, 8'hF0);
    tick();
    req("bp mid", 32'h2008, 8'd0, 8'hFF);
    tick();
    req("bp tail", 32'h2010, 8'd0, 8'h0F);
    tick();
    chk("bp done", 32'(done_o), 32'd1);
    tick();

    req_ready_i = 1'b0;
    go(32'h3000, 32'd4096);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    req("abort hold", 32'h3000, 8'd255, 8'hFF);
    tick();
    chk("abort hold2", 32'(req_valid_o), 32'd1);
    req_ready_i = 1'b1;
    tick();
    chk("abort valid", 32'(req_valid_o), 32'd0);
    chk("abort busy", 32'(busy_o), 32'd0);
    chk("abort done", 32'(done_o), 32'd0);
    tick();
    chk("abort done2", 32'(done_o), 32'd0);
    chk("abort idle", 32'(busy_o), 32'd0);

    go(32'h5000, 32'd8);
    abort_i = 1'b1;
    req("last+abort", 32'h5000, 8'd0, 8'hFF);
    tick();
    abort_i = 1'b0;
    chk("last+abort done", 32'(done_o), 32'd1);
    tick();

    req_ready_i = 1'b0;
    go(32'h4000, 32'd64);
    chk("rst pre", 32'(req_valid_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst async", 32'(req_valid_o), 32'd0);
    chk("rst busy async", 32'(busy_o), 32'd0);
    tick();
    rst = 1'b0;
    req_ready_i = 1'b1;
    tick();

    go(32'h6000, 32'd0);
    chk("zero valid", 32'(req_valid_o), 32'd0);
    chk("zero done", 32'(done_o), 32'd1);
    tick();
    chk("zero done off", 32'(done_o), 32'd0);
    chk("zero valid2", 32'(req_valid_o), 32'd0);

`ifdef DMA_STREAMER_FIXED_ADDR_EN
    mode_fixed_i = 1'b1;
    go(32'h2000, 32'd24);
    mode_fixed_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req("fixed", 32'h2000, 8'd0, 8'hFF);
      tick();
    end
    chk("fixed done", 32'(done_o), 32'd1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
